// File: rtl/rggen_irq_coalescer_pkg.sv
// Shared state encoding and build options for the interrupt coalescer.
// The holdoff path is built only when RGGEN_IRQ_COALESCER_HOLDOFF_EN is defined.
package rggen_irq_coalescer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ASSERT  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

`ifdef RGGEN_IRQ_COALESCER_HOLDOFF_EN
  localparam bit HOLDOFF_EN = 1'b1;
`else
  localparam bit HOLDOFF_EN = 1'b0;
`endif

  // Observable snapshot of the FSM, for debug and checker binding.
  typedef struct packed {
    state_e state;
    logic   irq;
  } coalescer_dbg_t;

endpackage

// File: rtl/rggen_popcount_sat.sv
// Combinational population count of a vector, saturated to OUT_WIDTH bits.
module rggen_popcount_sat #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 4
) (
  input  logic [WIDTH-1:0]     i_vec,
  output logic [OUT_WIDTH-1:0] o_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int MW = (CW > OUT_WIDTH) ? CW : OUT_WIDTH;

  logic [CW-1:0] w_sum;
  logic [MW-1:0] w_wide;
  logic [MW-1:0] w_max;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum = w_sum + CW'(i_vec[i]);
    end
  end

  assign w_wide  = MW'(w_sum);
  assign w_max   = MW'({OUT_WIDTH{1'b1}});
  assign o_count = (w_wide > w_max) ? {OUT_WIDTH{1'b1}} : w_wide[OUT_WIDTH-1:0];

endmodule

// File: rtl/rggen_irq_coalescer.sv
// Interrupt coalescer: counts fresh status-bit rises, fires on threshold or timeout.
// Optional minimum irq-low gap built with RGGEN_IRQ_COALESCER_HOLDOFF_EN.
module rggen_irq_coalescer
  import rggen_irq_coalescer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 4,
  parameter int TIMER_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic [WIDTH-1:0]       i_status,
  input  logic [COUNT_WIDTH-1:0] i_threshold,
  input  logic [TIMER_WIDTH-1:0] i_timeout,
`ifdef RGGEN_IRQ_COALESCER_HOLDOFF_EN
  input  logic [TIMER_WIDTH-1:0] i_holdoff,
`endif
  output logic                   o_irq,
  output logic [COUNT_WIDTH-1:0] o_event_count,
  output logic                   o_busy
);

  state_e                 r_state;
  logic [WIDTH-1:0]       r_status_d;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic                   r_irq;

  logic [WIDTH-1:0]       w_rise;
  logic [COUNT_WIDTH-1:0] w_n;
  logic [COUNT_WIDTH:0]   w_sum;
  logic [COUNT_WIDTH-1:0] w_next_count;
  logic [COUNT_WIDTH-1:0] w_thr_eff;
  logic [TIMER_WIDTH:0]   w_timer_inc;
  logic [TIMER_WIDTH-1:0] w_timer_sat;
  logic                   w_status_nz;
  logic                   w_thr_hit;
  logic                   w_timeout_hit;
  coalescer_dbg_t         w_dbg;

  // Only fresh edges count; bits already high were seen by r_status_d.
  assign w_rise = i_status & ~r_status_d;

  rggen_popcount_sat #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (COUNT_WIDTH)
  ) u_popcount (
    .i_vec   (w_rise),
    .o_count (w_n)
  );

  assign w_sum        = {1'b0, r_count} + {1'b0, w_n};
  assign w_next_count = w_sum[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : w_sum[COUNT_WIDTH-1:0];
  assign w_thr_eff    = (i_threshold == '0) ? COUNT_WIDTH'(1) : i_threshold;
  assign w_thr_hit    = (w_next_count >= w_thr_eff);
  assign w_status_nz  = (i_status != '0);

  // Compared one bit wider so timer+1 is exact even at the saturated maximum.
  assign w_timer_inc   = {1'b0, r_timer} + (TIMER_WIDTH+1)'(1);
  assign w_timer_sat   = w_timer_inc[TIMER_WIDTH] ? {TIMER_WIDTH{1'b1}} : w_timer_inc[TIMER_WIDTH-1:0];
  assign w_timeout_hit = (i_timeout != '0) && (w_timer_inc >= {1'b0, i_timeout});

`ifdef RGGEN_IRQ_COALESCER_HOLDOFF_EN
  logic w_holdoff_done;
  assign w_holdoff_done = (w_timer_inc >= {1'b0, i_holdoff});
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_status_d <= '0;
      r_count    <= '0;
      r_timer    <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_status_d <= i_status;
      if (!i_enable) begin
        r_state <= ST_IDLE;
        r_count <= '0;
        r_timer <= '0;
        r_irq   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_status_nz) begin
              r_count <= w_next_count;
              r_timer <= '0;
              if (w_thr_hit) begin
                r_state <= ST_ASSERT;
                r_irq   <= 1'b1;
              end else begin
                r_state <= ST_COLLECT;
              end
            end
          end
          ST_COLLECT: begin
            if (!w_status_nz) begin
              r_state <= ST_IDLE;
              r_count <= '0;
              r_timer <= '0;
            end else begin
              r_count <= w_next_count;
              r_timer <= w_timer_sat;
              if (w_thr_hit || w_timeout_hit) begin
                r_state <= ST_ASSERT;
                r_irq   <= 1'b1;
              end
            end
          end
          ST_ASSERT: begin
            // Rises are ignored here; software clearing everything ends the episode.
            if (!w_status_nz) begin
              r_count <= '0;
              r_irq   <= 1'b0;
`ifdef RGGEN_IRQ_COALESCER_HOLDOFF_EN
              r_state <= ST_HOLDOFF;
              r_timer <= '0;
`else
              r_state <= ST_IDLE;
`endif
            end
          end
`ifdef RGGEN_IRQ_COALESCER_HOLDOFF_EN
          ST_HOLDOFF: begin
            r_count <= w_next_count;
            r_timer <= w_timer_sat;
            if (w_holdoff_done) begin
              r_timer <= '0;
              if (w_status_nz) begin
                r_state <= ST_COLLECT;
              end else begin
                r_state <= ST_IDLE;
                r_count <= '0;
              end
            end
          end
`endif
          default: begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_timer <= '0;
            r_irq   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign w_dbg.state = r_state;
  assign w_dbg.irq   = r_irq;

  assign o_irq         = w_dbg.irq;
  assign o_busy        = (w_dbg.state != ST_IDLE);
  assign o_event_count = r_count;

endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Directed scoreboard bench for rggen_irq_coalescer (default widths plus a 2-bit counter instance).
module tb_rggen_irq_coalescer;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_enable;
  logic [7:0] i_status;
  logic [3:0] i_threshold;
  logic [7:0] i_timeout;
  logic [7:0] i_holdoff;
  logic       o_irq;
  logic [3:0] o_event_count;
  logic       o_busy;

  logic [7:0] i_status2;
  logic [1:0] i_threshold2;
  logic       o_irq2;
  logic [1:0] o_event_count2;
  logic       o_busy2;

  logic [5:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  rggen_irq_coalescer #(.WIDTH(8), .COUNT_WIDTH(4), .TIMER_WIDTH(8)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_enable      (i_enable),
    .i_status      (i_status),
    .i_threshold   (i_threshold),
    .i_timeout     (i_timeout),
`ifdef RGGEN_IRQ_COALESCER_HOLDOFF_EN
    .i_holdoff     (i_holdoff),
`endif
    .o_irq         (o_irq),
    .o_event_count (o_event_count),
    .o_busy        (o_busy)
  );

  rggen_irq_coalescer #(.WIDTH(8), .COUNT_WIDTH(2), .TIMER_WIDTH(8)) dut2 (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_enable      (i_enable),
    .i_status      (i_status2),
    .i_threshold   (i_threshold2),
    .i_timeout     (i_timeout),
`ifdef RGGEN_IRQ_COALESCER_HOLDOFF_EN
    .i_holdoff     (i_holdoff),
`endif
    .o_irq         (o_irq2),
    .o_event_count (o_event_count2),
    .o_busy        (o_busy2)
  );

  // Drive one cycle on the main instance; expected {irq, busy, count} after the edge.
  task automatic cyc(input logic [7:0] st, input logic e_irq, input logic e_busy,
                     input logic [3:0] e_cnt, input string tag);
    logic [5:0] obs;
    logic [5:0] exp;
    i_status = st;
    exp_q.push_back({e_irq, e_busy, e_cnt});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    obs = {o_irq, o_busy, o_event_count};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Same for the 2-bit-counter instance.
  task automatic cyc2(input logic [7:0] st, input logic e_irq, input logic e_busy,
                      input logic [1:0] e_cnt, input string tag);
    logic [5:0] obs;
    logic [5:0] exp;
    i_status2 = st;
    exp_q.push_back({e_irq, e_busy, 2'b00, e_cnt});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    obs = {o_irq2, o_busy2, 2'b00, o_event_count2};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    i_rst        = 1'b1;
    i_enable     = 1'b1;
    i_status     = 8'h00;
    i_threshold  = 4'd3;
    i_timeout    = 8'd0;
    i_holdoff    = 8'd0;
    i_status2    = 8'h00;
    i_threshold2 = 2'd3;

    cyc(8'h00, 1'b0, 1'b0, 4'd0, "reset");
    i_rst = 1'b0;
    cyc(8'h00, 1'b0, 1'b0, 4'd0, "idle");

    // Threshold path: three single-bit rises, threshold 3.
    cyc(8'h01, 1'b0, 1'b1, 4'd1, "thr_c1");
    cyc(8'h03, 1'b0, 1'b1, 4'd2, "thr_c2");
    cyc(8'h07, 1'b1, 1'b1, 4'd3, "thr_fire");
    cyc(8'h0F, 1'b1, 1'b1, 4'd3, "assert_hold");
    cyc(8'h00, 1'b0, 1'b0, 4'd0, "thr_drop");

    // Timeout path: threshold out of reach, timeout 5.
    i_threshold = 4'd15;
    i_timeout   = 8'd5;
    cyc(8'h10, 1'b0, 1'b1, 4'd1, "to_enter");
    for (int k = 0; k < 4; k++) cyc(8'h10, 1'b0, 1'b1, 4'd1, "to_wait");
    cyc(8'h10, 1'b1, 1'b1, 4'd1, "to_fire");
    cyc(8'h00, 1'b0, 1'b0, 4'd0, "to_drop");

    // Timer disabled: never asserts.
    i_timeout = 8'd0;
    cyc(8'h10, 1'b0, 1'b1, 4'd1, "to_off_enter");
    for (int k = 0; k < 20; k++) cyc(8'h10, 1'b0, 1'b1, 4'd1, "to_off_hold");
    cyc(8'h00, 1'b0, 1'b0, 4'd0, "to_off_drop");

    // Threshold 0 behaves as 1.
    i_threshold = 4'd0;
    cyc(8'h02, 1'b1, 1'b1, 4'd1, "thr0_fire");
    cyc(8'h00, 1'b0, 1'b0, 4'd0, "thr0_drop");

    // Early read-clear while collecting.
    i_threshold = 4'd4;
    cyc(8'h01, 1'b0, 1'b1, 4'd1, "early_c1");
    cyc(8'h03, 1'b0, 1'b1, 4'd2, "early_c2");
    cyc(8'h00, 1'b0, 1'b0, 4'd0, "early_clear");

    // Simultaneous threshold and timeout.
    i_threshold = 4'd2;
    i_timeout   = 8'd1;
    cyc(8'h01, 1'b0, 1'b1, 4'd1, "sim_c1");
    cyc(8'h03, 1'b1, 1'b1, 4'd2, "sim_fire");
    cyc(8'h00, 1'b0, 1'b0, 4'd0, "sim_drop");
    i_timeout = 8'd0;

    // Saturation on the 2-bit counter instance.
    cyc2(8'hFF, 1'b1, 1'b1, 2'd3, "sat_fire");
    cyc2(8'h00, 1'b0, 1'b0, 2'd0, "sat_drop");
    cyc2(8'h03, 1'b0, 1'b1, 2'd2, "sat_c2");
    cyc2(8'h07, 1'b1, 1'b1, 2'd3, "sat_c3");
    cyc2(8'h00, 1'b0, 1'b0, 2'd0, "sat_drop2");

    // Enable: drop in ASSERT, then re-enable with status held high.
    i_threshold = 4'd1;
    cyc(8'hFF, 1'b1, 1'b1, 4'd8, "en_fire");
    i_enable = 1'b0;
    cyc(8'hFF, 1'b0, 1'b0, 4'd0, "en_off");
    cyc(8'hFF, 1'b0, 1'b0, 4'd0, "en_off_hold");
    i_enable = 1'b1;
    cyc(8'hFF, 1'b0, 1'b1, 4'd0, "en_on_norise");
    cyc(8'hFF, 1'b0, 1'b1, 4'd0, "en_on_hold");
    cyc(8'h00, 1'b0, 1'b0, 4'd0, "en_drop");

    // Reset mid-COLLECT.
    i_threshold = 4'd15;
    cyc(8'h01, 1'b0, 1'b1, 4'd1, "rst_c1");
    i_rst = 1'b1;
    cyc(8'h03, 1'b0, 1'b0, 4'd0, "rst_mid");
    i_rst = 1'b0;
    cyc(8'h00, 1'b0, 1'b0, 4'd0, "rst_after");

`ifdef RGGEN_IRQ_COALESCER_HOLDOFF_EN
    // Holdoff: minimum irq-low gap of 4 before re-assertion through COLLECT.
    i_threshold = 4'd1;
    i_holdoff   = 8'd4;
    cyc(8'h01, 1'b1, 1'b1, 4'd1, "ho_fire");
    cyc(8'h00, 1'b0, 1'b1, 4'd0, "ho_enter");
    for (int k = 0; k < 3; k++) cyc(8'h01, 1'b0, 1'b1, 4'd1, "ho_wait");
    cyc(8'h01, 1'b0, 1'b1, 4'd1, "ho_collect");
    cyc(8'h01, 1'b1, 1'b1, 4'd1, "ho_refire");
    cyc(8'h00, 1'b0, 1'b1, 4'd0, "ho_enter2");
    i_holdoff = 8'd0;
    cyc(8'h00, 1'b0, 1'b0, 4'd0, "ho_zero_exit");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rggen_irq_coalescer.md
Name: rggen_irq_coalescer

Overview:
- Downstream consumer of the masked status vectors produced by read-to-clear bit fields; drives one interrupt line toward the host.
- Counts newly set status bits and raises the interrupt when an event threshold is met or a timeout expires, whichever comes first.
- Drops the interrupt once software has read-cleared every status bit.
- Sits between the register block's status outputs and the SoC interrupt controller.

Parameters:
- WIDTH, 8, number of status bits observed.
- COUNT_WIDTH, 4, width of the event counter and threshold.
- TIMER_WIDTH, 8, width of the timeout (and holdoff) timer.

Ports:
- i_clk  input  1  clock; the block has one clock, and all logic is on its rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_enable  input  1  coalescer enable; low forces IDLE and o_irq low.
- i_status  input  WIDTH  masked status vector from read-to-clear bit fields.
- i_threshold  input  COUNT_WIDTH  event count that triggers the interrupt; 0 is treated as 1.
- i_timeout  input  TIMER_WIDTH  cycles in COLLECT before forced assertion; 0 disables the timer.
- o_irq  output  1  registered interrupt request.
- o_event_count  output  COUNT_WIDTH  current saturating event count.
- o_busy  output  1  high when the state is not IDLE.

Behaviour:
- Reset (i_rst high at an edge) sets: state IDLE, r_status_d 0, count 0, timer 0, o_irq 0, o_busy 0. Reset mid-operation aborts everything in the same edge.
- r_status_d registers i_status every cycle, including while i_enable is low.
- rise = i_status & ~r_status_d. n = popcount(rise), saturated to COUNT_WIDTH.
- next_count = count + n, saturating at all-ones.
- thr_eff = max(i_threshold, 1).
- States and transitions (IDLE=0, COLLECT=1, ASSERT=2, HOLDOFF=3 when the optional feature is built):
  - IDLE, i_status != 0: if next_count >= thr_eff, go to ASSERT; else go to COLLECT. count <= next_count, timer <= 0.
  - COLLECT, i_status == 0: go to IDLE; count and timer cleared; no irq (software read-cleared early).
  - COLLECT, otherwise: count <= next_count, timer <= timer + 1. Go to ASSERT if next_count >= thr_eff, or if i_timeout != 0 and timer + 1 >= i_timeout.
  - ASSERT: new rises are ignored and count is held. When i_status == 0, go to IDLE and clear count.
- o_irq is registered and equals (state == ASSERT).
- Latency: a status bit rising in cycle N (threshold met) gives o_irq high in cycle N+1. In the timeout path, o_irq goes high i_timeout cycles after the state enters COLLECT.
- o_irq falls in the cycle after i_status becomes 0.
- i_enable low: state goes to IDLE, count and timer clear, and o_irq is 0 from the next cycle. Bits already high when enable rises do not count as rises; only fresh edges trigger.
- Simultaneous threshold and timeout in the same cycle: single transition to ASSERT.
- Counter saturates and never wraps. The timer stops at its maximum and cannot wrap.
- i_threshold and i_timeout are sampled every cycle, not latched.

Optional Feature:
- Macro: RGGEN_IRQ_COALESCER_HOLDOFF_EN.
- Defined:
  - Adds port i_holdoff (input, TIMER_WIDTH), the minimum irq-low gap.
  - ASSERT with i_status == 0 goes to HOLDOFF, not IDLE; timer <= 0.
  - In HOLDOFF: o_irq is 0, rises accumulate into count, and timer increments.
  - Exit when timer + 1 >= i_holdoff (immediately if i_holdoff is 0). Next state is COLLECT with timer <= 0 if i_status != 0, else IDLE with count cleared.
- Undefined: no i_holdoff port and no HOLDOFF state; ASSERT goes directly to IDLE.

Decomposition:
- Shared defines include: state encoding localparams (IDLE, COLLECT, ASSERT, HOLDOFF), 2-bit state width, and the holdoff macro guard.
- One sub-module: rggen_popcount_sat (WIDTH, OUT_WIDTH). Combinational population count saturated to OUT_WIDTH; reusable by other status blocks.

Test Plan:
- Threshold path: WIDTH=8, i_threshold=3, i_timeout=0. Bits 0, 1, 2 rise in cycles 1, 2, 3. count reads 1, 2, then o_irq=1 in cycle 4. Drop i_status to 0 and o_irq=0 the next cycle.
- Timeout path: i_threshold=15, i_timeout=5. Bit 4 rises in cycle N, so state is COLLECT at N+1 and o_irq rises at N+6. With i_timeout=0 the irq never asserts.
- Early read-clear: i_threshold=4, two rises, then i_status=0 while in COLLECT. State goes to IDLE, count=0, o_irq never high.
- Saturation and simultaneous rises: 8 bits rise in one cycle with COUNT_WIDTH=2. count=3 (saturated), and o_irq=1 next cycle with i_threshold=3.
- Enable and reset: in ASSERT, drop i_enable, then o_irq=0 the next cycle and state is IDLE. Re-enable with status still 0xFF and no irq follows. Assert i_rst mid-COLLECT and all outputs read 0 the next cycle.
- Holdoff (macro defined): i_holdoff=4, clear status in ASSERT, raise a bit 1 cycle later. o_irq stays low for 4 cycles, then re-asserts via COLLECT once threshold=1 is met.
